// File: rtl/mem_rr_arbiter_if.sv
// Bus bundle for mem_rr_arbiter: per-consumer request/response lanes plus the shared memory channel.
// master = arbiter side, slave = consumers and memory.
interface mem_rr_arbiter_if #(
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 16,
  parameter int unsigned NUM_CONSUMERS = 4
);
  logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport master (
    input  consumer_read_valid, consumer_read_address,
    output consumer_read_ready, consumer_read_data,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_write_ready,
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    output consumer_read_valid, consumer_read_address,
    input  consumer_read_ready, consumer_read_data,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory read/write channel among NUM_CONSUMERS requesters,
// with a per-access watchdog and a sticky timeout flag.
module mem_rr_arbiter #(
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned DATA_BITS      = 16,
  parameter int unsigned NUM_CONSUMERS  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  mem_rr_arbiter_if.master bus,
  output logic busy,
  output logic [(NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1)-1:0] grant_id,
  output logic timeout_error
);

  localparam int unsigned GRANT_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int unsigned WD_BITS    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    READ_RELAY,
    WRITE_RELAY
  } state_t;

  state_t                                  state;
  logic [GRANT_BITS-1:0]                   rr_ptr;
  logic [WD_BITS-1:0]                      wd_cnt;
  logic                                    mem_rv_q;
  logic [ADDR_BITS-1:0]                    mem_ra_q;
  logic                                    mem_wv_q;
  logic [ADDR_BITS-1:0]                    mem_wa_q;
  logic [DATA_BITS-1:0]                    mem_wd_q;
  logic [NUM_CONSUMERS-1:0]                rd_ready_q;
  logic [NUM_CONSUMERS-1:0]                wr_ready_q;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_q;

  logic                  pick_found_c;
  logic [GRANT_BITS-1:0] pick_id_c;
  logic [GRANT_BITS-1:0] scan_idx_c;
  logic                  pick_read_c;
  logic [GRANT_BITS-1:0] next_ptr_c;
  logic                  wd_expire_c;

  // Scan consumers starting at rr_ptr; first with any request wins
  always_comb begin
    pick_found_c = 1'b0;
    pick_id_c    = '0;
    scan_idx_c   = '0;
    for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
      scan_idx_c = GRANT_BITS'((32'(rr_ptr) + k) % NUM_CONSUMERS);
      if (!pick_found_c && (bus.consumer_read_valid[scan_idx_c] || bus.consumer_write_valid[scan_idx_c])) begin
        pick_found_c = 1'b1;
        pick_id_c    = scan_idx_c;
      end
    end
    pick_read_c = bus.consumer_read_valid[pick_id_c];
    next_ptr_c  = (pick_id_c == GRANT_BITS'(NUM_CONSUMERS - 1)) ? '0 : pick_id_c + GRANT_BITS'(1);
  end

  assign wd_expire_c = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_BITS'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      wd_cnt        <= '0;
      grant_id      <= '0;
      timeout_error <= 1'b0;
      mem_rv_q      <= 1'b0;
      mem_ra_q      <= '0;
      mem_wv_q      <= 1'b0;
      mem_wa_q      <= '0;
      mem_wd_q      <= '0;
      rd_ready_q    <= '0;
      wr_ready_q    <= '0;
      rd_data_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found_c) begin
            grant_id <= pick_id_c;
            rr_ptr   <= next_ptr_c;
            wd_cnt   <= '0;
            if (pick_read_c) begin
              mem_rv_q <= 1'b1;
              mem_ra_q <= bus.consumer_read_address[pick_id_c];
              state    <= READ_WAIT;
            end else begin
              mem_wv_q <= 1'b1;
              mem_wa_q <= bus.consumer_write_address[pick_id_c];
              mem_wd_q <= bus.consumer_write_data[pick_id_c];
              state    <= WRITE_WAIT;
            end
          end
        end
        // Memory response beats a simultaneous watchdog expiry
        READ_WAIT: begin
          if (bus.mem_read_ready) begin
            mem_rv_q             <= 1'b0;
            rd_data_q[grant_id]  <= bus.mem_read_data;
            rd_ready_q[grant_id] <= 1'b1;
            state                <= READ_RELAY;
          end else if (wd_expire_c) begin
            mem_rv_q             <= 1'b0;
            rd_data_q[grant_id]  <= '0;
            rd_ready_q[grant_id] <= 1'b1;
            timeout_error        <= 1'b1;
            state                <= READ_RELAY;
          end else begin
            wd_cnt <= wd_cnt + WD_BITS'(1);
          end
        end
        WRITE_WAIT: begin
          if (bus.mem_write_ready) begin
            mem_wv_q             <= 1'b0;
            wr_ready_q[grant_id] <= 1'b1;
            state                <= WRITE_RELAY;
          end else if (wd_expire_c) begin
            mem_wv_q             <= 1'b0;
            wr_ready_q[grant_id] <= 1'b1;
            timeout_error        <= 1'b1;
            state                <= WRITE_RELAY;
          end else begin
            wd_cnt <= wd_cnt + WD_BITS'(1);
          end
        end
        READ_RELAY: begin
          if (!bus.consumer_read_valid[grant_id]) begin
            rd_ready_q[grant_id] <= 1'b0;
            state                <= IDLE;
          end
        end
        WRITE_RELAY: begin
          if (!bus.consumer_write_valid[grant_id]) begin
            wr_ready_q[grant_id] <= 1'b0;
            state                <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy                     = (state != IDLE);
  assign bus.mem_read_valid       = mem_rv_q;
  assign bus.mem_read_address     = mem_ra_q;
  assign bus.mem_write_valid      = mem_wv_q;
  assign bus.mem_write_address    = mem_wa_q;
  assign bus.mem_write_data       = mem_wd_q;
  assign bus.consumer_read_ready  = rd_ready_q;
  assign bus.consumer_read_data   = rd_data_q;
  assign bus.consumer_write_ready = wr_ready_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scenario bench for mem_rr_arbiter: expected grants/responses queued at stimulus time,
// popped and compared when the arbiter acts on the memory channel.
module tb_mem_rr_arbiter;
  localparam int unsigned AB = 8;
  localparam int unsigned DB = 16;
  localparam int unsigned NC = 4;
  localparam int unsigned TO = 4;

  logic       clk;
  logic       reset;
  logic       busy;
  logic [1:0] grant_id;
  logic       timeout_error;

  mem_rr_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC)) bus ();

  mem_rr_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(NC), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .busy          (busy),
    .grant_id      (grant_id),
    .timeout_error (timeout_error)
  );

  typedef struct {
    int          id;
    bit          is_read;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout sim ran past time limit");
    $fatal(1, "global timeout");
  end

  // At most one ready bit per direction, never both memory valids
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      checks++;
      if ($countones(bus.consumer_read_ready) > 1 || $countones(bus.consumer_write_ready) > 1 ||
          (bus.mem_read_valid && bus.mem_write_valid)) begin
        errors++;
        $display("FAIL onehot rd_ready=%b wr_ready=%b mrv=%b mwv=%b required at most one high",
                 bus.consumer_read_ready, bus.consumer_write_ready, bus.mem_read_valid, bus.mem_write_valid);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.consumer_read_valid    = '0;
    bus.consumer_read_address  = '0;
    bus.consumer_write_valid   = '0;
    bus.consumer_write_address = '0;
    bus.consumer_write_data    = '0;
    bus.mem_read_ready         = 1'b0;
    bus.mem_read_data          = '0;
    bus.mem_write_ready        = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_read_valid || bus.mem_write_valid) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.consumer_read_valid   = '1;
    bus.consumer_write_valid  = '1;
    bus.consumer_read_address = '1;
    bus.mem_read_ready        = 1'b1;
    bus.mem_write_ready       = 1'b1;
    do_reset();
    reset = 1'b1;
    step();
    checks++;
    if (bus.mem_read_valid !== 1'b0 || bus.mem_write_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mem_valid got %b/%b required 0/0", bus.mem_read_valid, bus.mem_write_valid);
    end
    checks++;
    if (bus.mem_read_address !== 8'h00 || bus.mem_write_address !== 8'h00 || bus.mem_write_data !== 16'h0000) begin
      errors++; $display("FAIL reset_mem_bus got %h/%h/%h required 0", bus.mem_read_address, bus.mem_write_address, bus.mem_write_data);
    end
    checks++;
    if (bus.consumer_read_ready !== 4'b0 || bus.consumer_write_ready !== 4'b0 || bus.consumer_read_data !== 64'h0) begin
      errors++; $display("FAIL reset_consumer got %b/%b/%h required 0", bus.consumer_read_ready, bus.consumer_write_ready, bus.consumer_read_data);
    end
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd0 || timeout_error !== 1'b0) begin
      errors++; $display("FAIL reset_status got busy=%b grant=%0d to=%b required 0", busy, grant_id, timeout_error);
    end
    clear_inputs();
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single_read();
    exp_t e;
    bit   ok;
    clear_inputs();
    do_reset();
    bus.consumer_read_valid[2]   = 1'b1;
    bus.consumer_read_address[2] = 8'h3C;
    sb.push_back('{2, 1'b1, 8'h3C, 16'hBEEF});
    wait_grant(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_grant got no grant required mem_read_valid"); return; end
    e = sb.pop_front();
    checks++;
    if (grant_id !== 2'(e.id) || bus.mem_read_address !== e.addr || busy !== 1'b1) begin
      errors++; $display("FAIL single_issue got id=%0d addr=%h busy=%b required id=%0d addr=%h busy=1", grant_id, bus.mem_read_address, busy, e.id, e.addr);
    end
    bus.consumer_read_address[2] = 8'h00;
    step();
    step();
    checks++;
    if (bus.mem_read_address !== e.addr || bus.mem_read_valid !== 1'b1) begin
      errors++; $display("FAIL single_hold got addr=%h v=%b required %h v=1", bus.mem_read_address, bus.mem_read_valid, e.addr);
    end
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = e.data;
    step();
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data  = 16'h0000;
    checks++;
    if (bus.consumer_read_ready !== 4'b0100 || bus.consumer_read_data[e.id] !== e.data || bus.mem_read_valid !== 1'b0) begin
      errors++; $display("FAIL single_resp got rdy=%b data=%h mrv=%b required 0100 %h 0", bus.consumer_read_ready, bus.consumer_read_data[e.id], bus.mem_read_valid, e.data);
    end
    step();
    step();
    checks++;
    if (bus.consumer_read_ready !== 4'b0100) begin
      errors++; $display("FAIL single_relay_hold got rdy=%b required 0100", bus.consumer_read_ready);
    end
    bus.consumer_read_valid[2] = 1'b0;
    step();
    checks++;
    if (bus.consumer_read_ready !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL single_release got rdy=%b busy=%b required 0000 0", bus.consumer_read_ready, busy);
    end
  endtask

  task automatic test_rr_order();
    exp_t e;
    bit   ok;
    int   order[5] = '{0, 1, 2, 3, 0};
    clear_inputs();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.consumer_read_valid[i]   = 1'b1;
      bus.consumer_read_address[i] = 8'(8'h40 + i);
    end
    step();
    step();
    reset = 1'b0;
    foreach (order[k]) sb.push_back('{order[k], 1'b1, 8'(8'h40 + order[k]), 16'(16'h1000 + order[k])});
    for (int k = 0; k < 5; k++) begin
      wait_grant(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_grant_%0d got no grant required one", k); return; end
      e = sb.pop_front();
      checks++;
      if (grant_id !== 2'(e.id) || bus.mem_read_address !== e.addr) begin
        errors++; $display("FAIL rr_order_%0d got id=%0d addr=%h required id=%0d addr=%h", k, grant_id, bus.mem_read_address, e.id, e.addr);
      end
      bus.mem_read_ready = 1'b1;
      bus.mem_read_data  = e.data;
      step();
      bus.mem_read_ready = 1'b0;
      checks++;
      if (bus.consumer_read_ready !== 4'(1 << e.id) || bus.consumer_read_data[e.id] !== e.data) begin
        errors++; $display("FAIL rr_resp_%0d got rdy=%b data=%h required %b %h", k, bus.consumer_read_ready, bus.consumer_read_data[e.id], 4'(1 << e.id), e.data);
      end
      bus.consumer_read_valid[e.id] = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0 || bus.mem_read_valid !== 1'b0) begin
        errors++; $display("FAIL rr_exit_gap_%0d got busy=%b mrv=%b required 0 0", k, busy, bus.mem_read_valid);
      end
      bus.consumer_read_valid[e.id] = 1'b1;
    end
    bus.consumer_read_valid = '0;
  endtask

  task automatic test_read_write_priority();
    exp_t e;
    bit   ok;
    clear_inputs();
    do_reset();
    bus.consumer_read_valid[1]    = 1'b1;
    bus.consumer_read_address[1]  = 8'h10;
    bus.consumer_write_valid[1]   = 1'b1;
    bus.consumer_write_address[1] = 8'h20;
    bus.consumer_write_data[1]    = 16'h1234;
    sb.push_back('{1, 1'b1, 8'h10, 16'h5A5A});
    sb.push_back('{1, 1'b0, 8'h20, 16'h1234});
    for (int k = 0; k < 2; k++) begin
      wait_grant(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rw_grant_%0d got no grant required one", k); return; end
      e = sb.pop_front();
      checks++;
      if (grant_id !== 2'(e.id) || bus.mem_read_valid !== e.is_read || bus.mem_write_valid !== !e.is_read) begin
        errors++; $display("FAIL rw_kind_%0d got id=%0d rv=%b wv=%b required id=%0d read=%b", k, grant_id, bus.mem_read_valid, bus.mem_write_valid, e.id, e.is_read);
      end
      if (e.is_read) begin
        checks++;
        if (bus.mem_read_address !== e.addr) begin
          errors++; $display("FAIL rw_raddr got %h required %h", bus.mem_read_address, e.addr);
        end
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = e.data;
        step();
        bus.mem_read_ready = 1'b0;
        checks++;
        if (bus.consumer_read_ready !== 4'b0010 || bus.consumer_read_data[1] !== e.data || bus.consumer_write_ready !== 4'b0) begin
          errors++; $display("FAIL rw_rresp got rdy=%b data=%h wrdy=%b required 0010 %h 0000", bus.consumer_read_ready, bus.consumer_read_data[1], bus.consumer_write_ready, e.data);
        end
        bus.consumer_read_valid[1] = 1'b0;
        step();
      end else begin
        bus.consumer_write_address[1] = 8'h77;
        bus.consumer_write_data[1]    = 16'hFFFF;
        step();
        checks++;
        if (bus.mem_write_address !== e.addr || bus.mem_write_data !== e.data) begin
          errors++; $display("FAIL rw_whold got %h/%h required %h/%h", bus.mem_write_address, bus.mem_write_data, e.addr, e.data);
        end
        bus.mem_write_ready = 1'b1;
        step();
        bus.mem_write_ready = 1'b0;
        checks++;
        if (bus.consumer_write_ready !== 4'b0010 || bus.mem_write_valid !== 1'b0) begin
          errors++; $display("FAIL rw_wresp got wrdy=%b mwv=%b required 0010 0", bus.consumer_write_ready, bus.mem_write_valid);
        end
        bus.consumer_write_valid[1] = 1'b0;
        step();
        checks++;
        if (bus.consumer_write_ready !== 4'b0 || busy !== 1'b0) begin
          errors++; $display("FAIL rw_wrelease got wrdy=%b busy=%b required 0000 0", bus.consumer_write_ready, busy);
        end
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    bit   ok;
    clear_inputs();
    do_reset();
    bus.consumer_read_valid[0]   = 1'b1;
    bus.consumer_read_address[0] = 8'h55;
    sb.push_back('{0, 1'b1, 8'h55, 16'h0000});
    wait_grant(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_grant got no grant required one"); return; end
    e = sb.pop_front();
    step();
    step();
    step();
    checks++;
    if (bus.mem_read_valid !== 1'b1 || timeout_error !== 1'b0 || bus.consumer_read_ready !== 4'b0) begin
      errors++; $display("FAIL to_before got mrv=%b to=%b rdy=%b required 1 0 0000", bus.mem_read_valid, timeout_error, bus.consumer_read_ready);
    end
    step();
    checks++;
    if (bus.mem_read_valid !== 1'b0 || bus.consumer_read_ready !== 4'b0001 ||
        bus.consumer_read_data[e.id] !== e.data || timeout_error !== 1'b1) begin
      errors++; $display("FAIL to_expire got mrv=%b rdy=%b data=%h to=%b required 0 0001 %h 1", bus.mem_read_valid, bus.consumer_read_ready, bus.consumer_read_data[e.id], timeout_error, e.data);
    end
    bus.consumer_read_valid[0] = 1'b0;
    step();
    bus.mem_read_ready  = 1'b1;
    bus.mem_write_ready = 1'b1;
    step();
    step();
    bus.mem_read_ready  = 1'b0;
    bus.mem_write_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.consumer_read_ready !== 4'b0 || bus.consumer_write_ready !== 4'b0 || timeout_error !== 1'b1) begin
      errors++; $display("FAIL to_idle_ignore got busy=%b rdy=%b wrdy=%b to=%b required 0 0000 0000 1", busy, bus.consumer_read_ready, bus.consumer_write_ready, timeout_error);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (timeout_error !== 1'b0) begin
      errors++; $display("FAIL to_clear got %b required 0", timeout_error);
    end
  endtask

  task automatic test_timeout_tie();
    exp_t e;
    bit   ok;
    clear_inputs();
    do_reset();
    bus.consumer_read_valid[3]   = 1'b1;
    bus.consumer_read_address[3] = 8'h66;
    sb.push_back('{3, 1'b1, 8'h66, 16'hCAFE});
    wait_grant(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tie_grant got no grant required one"); return; end
    e = sb.pop_front();
    step();
    step();
    step();
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = e.data;
    step();
    bus.mem_read_ready = 1'b0;
    checks++;
    if (bus.consumer_read_ready !== 4'b1000 || bus.consumer_read_data[e.id] !== e.data || timeout_error !== 1'b0) begin
      errors++; $display("FAIL tie_resp got rdy=%b data=%h to=%b required 1000 %h 0", bus.consumer_read_ready, bus.consumer_read_data[e.id], timeout_error, e.data);
    end
    bus.consumer_read_valid[3] = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_write();
    exp_t e;
    bit   ok;
    clear_inputs();
    do_reset();
    bus.consumer_write_valid[1]   = 1'b1;
    bus.consumer_write_address[1] = 8'h99;
    bus.consumer_write_data[1]    = 16'hAAAA;
    wait_grant(ok);
    checks++;
    if (!ok || bus.mem_write_valid !== 1'b1 || grant_id !== 2'd1) begin
      errors++; $display("FAIL rst_mid_grant got ok=%b mwv=%b id=%0d required 1 1 1", ok, bus.mem_write_valid, grant_id);
    end
    reset = 1'b1;
    step();
    checks++;
    if (bus.mem_write_valid !== 1'b0 || busy !== 1'b0 || bus.consumer_write_ready !== 4'b0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL rst_mid_abort got mwv=%b busy=%b wrdy=%b id=%0d required 0 0 0000 0", bus.mem_write_valid, busy, bus.consumer_write_ready, grant_id);
    end
    bus.consumer_read_valid[3]   = 1'b1;
    bus.consumer_read_address[3] = 8'h33;
    sb.push_back('{1, 1'b0, 8'h99, 16'hAAAA});
    reset = 1'b0;
    wait_grant(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid_regrant got no grant required one"); return; end
    e = sb.pop_front();
    checks++;
    if (grant_id !== 2'(e.id) || bus.mem_write_valid !== 1'b1 || bus.mem_write_address !== e.addr || bus.mem_write_data !== e.data) begin
      errors++; $display("FAIL rst_mid_ptr got id=%0d mwv=%b addr=%h data=%h required %0d 1 %h %h", grant_id, bus.mem_write_valid, bus.mem_write_address, bus.mem_write_data, e.id, e.addr, e.data);
    end
    bus.mem_write_ready = 1'b1;
    step();
    bus.mem_write_ready = 1'b0;
    clear_inputs();
    step();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_rr_order();
    test_read_write_priority();
    test_timeout_tie();
    test_timeout();
    test_reset_mid_write();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d entries required 0", sb.size());
    end
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_rr_arbiter.md
MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_BITS, 8, memory address width
  DATA_BITS, 16, memory data width
  NUM_CONSUMERS, 4, requesters sharing one memory channel (>=1)
  TIMEOUT_CYCLES, 255, wait cycles before abandoning a memory access (0 = watchdog disabled)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  clock; all logic on rising edge
  reset  in  1  synchronous, active-high
  consumer_read_valid  in  NUM_CONSUMERS  per-consumer read request
  consumer_read_address  in  ADDR_BITS x NUM_CONSUMERS  read address
  consumer_read_ready  out  NUM_CONSUMERS  read response valid
  consumer_read_data  out  DATA_BITS x NUM_CONSUMERS  read response data
  consumer_write_valid  in  NUM_CONSUMERS  per-consumer write request
  consumer_write_address  in  ADDR_BITS x NUM_CONSUMERS  write address
  consumer_write_data  in  DATA_BITS x NUM_CONSUMERS  write data
  consumer_write_ready  out  NUM_CONSUMERS  write complete
  mem_read_valid / mem_read_address  out  1 / ADDR_BITS  memory read request
  mem_read_ready / mem_read_data  in  1 / DATA_BITS  memory read response
  mem_write_valid / mem_write_address / mem_write_data  out  1 / ADDR_BITS / DATA_BITS  memory write request
  mem_write_ready  in  1  memory write acknowledge
  busy  out  1  high whenever state != IDLE
  grant_id  out  clog2(NUM_CONSUMERS), min 1  consumer currently owning the channel
  timeout_error  out  1  sticky; set on any watchdog expiry

Function
REQ-003 States SHALL be IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY; all outputs registered.
REQ-004 In IDLE, arbiter SHALL scan consumers rr_ptr, rr_ptr+1, ... mod NUM_CONSUMERS and grant the first with read_valid or write_valid high.
REQ-005 If granted consumer has both valids high, read SHALL win; write served on a later grant.
REQ-006 On grant at edge E: grant_id<=j, rr_ptr<=(j+1) mod NUM_CONSUMERS, address/data latched, mem_*_valid<=1, state -> *_WAIT; mem valid visible the cycle after E.
REQ-007 mem_*_address and mem_write_data SHALL hold constant while in *_WAIT regardless of consumer inputs.
REQ-008 READ_WAIT, mem_read_ready sampled high: mem_read_valid<=0, consumer_read_data[j]<=mem_read_data, consumer_read_ready[j]<=1 -> READ_RELAY; WRITE_WAIT analogous without data.
REQ-009 *_RELAY: when consumer_*_valid[j] sampled low, consumer_*_ready[j]<=0 -> IDLE; otherwise hold indefinitely.
REQ-010 No grant SHALL occur in the cycle RELAY exits; earliest new grant at next edge with state IDLE.
REQ-011 Consumer dropping valid during *_WAIT SHALL NOT abort memory access; relay exits one cycle after response.
REQ-012 Watchdog: counter clears on grant, increments each *_WAIT cycle without ready; reaching TIMEOUT_CYCLES -> mem valid<=0, consumer ready<=1, read data<=0, timeout_error<=1, -> *_RELAY.
REQ-013 Memory ready on same edge as watchdog expiry SHALL take priority (normal completion, no error).
REQ-014 mem ready while IDLE or RELAY SHALL be ignored.
REQ-015 At most one consumer_*_ready bit and one mem_*_valid SHALL be high at any time.
REQ-016 NUM_CONSUMERS=1: rr_ptr and grant_id constant 0.

Reset
REQ-017 Reset SHALL force IDLE, rr_ptr=0, watchdog=0, and all outputs 0 (valids, readys, addresses, data, busy, grant_id, timeout_error).
REQ-018 Reset mid-transaction SHALL abandon the access immediately; next-cycle mem valid low; no response delivered.

Verification
V-1 Consumer 2 read addr 0x3C, mem returns 0xBEEF after 3 cycles -> mem_read_address=0x3C, consumer_read_data[2]=0xBEEF, ready[2] high until read_valid[2] drops.
V-2 All 4 consumers hold read_valid from reset -> grant order 0,1,2,3,0; each served once before repeat.
V-3 Consumer 1 read and write both valid, addr 0x10 / write 0x20 data 0x1234 -> read served first; write with 0x20/0x1234 on later grant.
V-4 TIMEOUT_CYCLES=4, memory never ready -> mem_read_valid drops after 4 wait cycles, read_ready high, data 0, timeout_error=1 until reset.
V-5 Reset asserted during WRITE_WAIT -> next cycle mem_write_valid=0, busy=0, no write_ready pulse, rr_ptr=0.
V-6 Mem ready coincides with watchdog expiry -> data delivered, timeout_error stays 0.
